sum_serial_tx: RTL



---
 rtl/sum_serial_tx_pkg.sv | 21 ++
 rtl/sum_serial_tx_bit_timer.sv | 36 +++
 rtl/sum_serial_tx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sum_serial_tx_pkg.sv
// Shared types and constants for the serial result transmitter.
// The parity feature is enabled by defining SUM_SERIAL_TX_PARITY_EN.
package sum_serial_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Serial bits per frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_w, input bit parity_en);
    return data_w + 2 + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/sum_serial_tx_bit_timer.sv
// Bit-period down-counter: bit_tick marks the last cycle of each serial bit.
// Holding clear reloads the counter so the next bit starts with a full period.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == '0)) begin
      cnt_d = CntMax;
    end else begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == '0);

endmodule

// File: rtl/sum_serial_tx.sv
// Serialises one adder result per handshake: start, data LSB-first, optional even parity, stop.
// Define SUM_SERIAL_TX_PARITY_EN to insert the parity bit.
module sum_serial_tx
  import sum_serial_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              bit_tick;

  // Timer is held in reload while idle so START always gets a full bit period.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == StIdle),
    .bit_tick(bit_tick)
  );

`ifdef SUM_SERIAL_TX_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if ((state_q == StIdle) && in_valid) begin
      parity_d = ^in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StStart;
          shift_d = in_data;
          idx_d   = '0;
        end
      end
      StStart: begin
        if (bit_tick) state_d = StData;
      end
      StData: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IdxMax) begin
            idx_d = '0;
`ifdef SUM_SERIAL_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
`ifdef SUM_SERIAL_TX_PARITY_EN
      StParity: begin
        if (bit_tick) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Line level is decoded from registered state only, so reset drives it high at once.
  always_comb begin
    tx_out = IDLE_LEVEL;
    unique case (state_q)
      StStart:  tx_out = START_LEVEL;
      StData:   tx_out = shift_q[0];
`ifdef SUM_SERIAL_TX_PARITY_EN
      StParity: tx_out = parity_q;
`endif
      default:  tx_out = IDLE_LEVEL;
    endcase
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StStop) && bit_tick;

endmodule
